// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// sweep state encoding and the address-width helper.
package regfile_mp_pkg;

  localparam int REG_SIZE_DEF = 32;
  localparam int REG_N_DEF    = 32;
  localparam int N_RD_DEF     = 2;

  // CLEAR zero-fills the array after reset; RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Address width for a file of n registers (n is a power of two, >= 2).
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One asynchronous read port of the register file.
// Returns zero for register 0 and while the file is still clearing.
// When REGFILE_BYPASS_EN is defined, a same-cycle write to the addressed
// register is forwarded to the output, write port 1 taking priority.
module regfile_rdport #(
  parameter int REG_SIZE = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                run,
  input  logic [REG_ADDR-1:0] raddr,
  input  logic [REG_SIZE-1:0] stored,
`ifdef REGFILE_BYPASS_EN
  input  logic                we0,
  input  logic [REG_ADDR-1:0] wreg0,
  input  logic [REG_SIZE-1:0] wdata0,
  input  logic                we1,
  input  logic [REG_ADDR-1:0] wreg1,
  input  logic [REG_SIZE-1:0] wdata1,
`endif
  output logic [REG_SIZE-1:0] rdata
);

  // Read mux: mask, zero register, then optional write forwarding.
  always_comb begin
    // NOTE: every output of a combinational block gets a default on entry;
    // an if without else would otherwise infer a latch.
    rdata = '0;
    if (run && (raddr != '0)) begin
      rdata = stored;
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wreg1 == raddr)) begin
        rdata = wdata1;
      end else if (we0 && (wreg0 == raddr)) begin
        rdata = wdata0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: N_RD asynchronous read ports, two synchronous
// write ports (port 1 wins on an address collision), register 0 fixed at 0.
// After reset a sweep zero-clears entries 1..REG_N-1 and holds ready low.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes
// to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int REG_SIZE = REG_SIZE_DEF,
  parameter  int REG_N    = REG_N_DEF,
  parameter  int N_RD     = N_RD_DEF,
  localparam int REG_ADDR = addr_w(REG_N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*REG_ADDR-1:0] rreg,
  output logic [N_RD*REG_SIZE-1:0] rdata,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [REG_ADDR-1:0]      wreg0,
  input  logic [REG_ADDR-1:0]      wreg1,
  input  logic [REG_SIZE-1:0]      wdata0,
  input  logic [REG_SIZE-1:0]      wdata1,
  output logic                     ready
);

  localparam logic [REG_ADDR-1:0] FIRST_ADDR = REG_ADDR'(1);
  localparam logic [REG_ADDR-1:0] LAST_ADDR  = REG_ADDR'(REG_N - 1);

  state_e              state_q, state_d;
  logic [REG_ADDR-1:0] ptr_q, ptr_d;
  logic                run;
  logic                clr_go;
  logic                wr0_go, wr1_go;
  logic [REG_SIZE-1:0] mem_q [REG_N];

  assign run   = (state_q == RUN);
  assign ready = run;

  // Sweep sequencing and write qualification.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_go  = 1'b0;
    wr0_go  = run && we0 && (wreg0 != '0);
    wr1_go  = run && we1 && (wreg1 != '0);
    if (state_q == CLEAR) begin
      clr_go = 1'b1;
      ptr_d  = ptr_q + FIRST_ADDR;
      if (ptr_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end
  end

  // State and sweep pointer registers; reset restarts the sweep at entry 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= FIRST_ADDR;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage: sweep clear, then the two write ports.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the post-reset sweep clears it one
    // entry per cycle so it can map onto plain RAM. Port 1 is assigned after
    // port 0, so on a shared address its value is the one that lands.
    if (!reset) begin
      if (clr_go) begin
        mem_q[ptr_q] <= '0;
      end
      if (wr0_go) begin
        mem_q[wreg0] <= wdata0;
      end
      if (wr1_go) begin
        mem_q[wreg1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [REG_ADDR-1:0] raddr;
    assign raddr = rreg[k*REG_ADDR +: REG_ADDR];

    regfile_rdport #(
      .REG_SIZE (REG_SIZE),
      .REG_ADDR (REG_ADDR)
    ) u_rdport (
      .run    (run),
      .raddr  (raddr),
      .stored (mem_q[raddr]),
`ifdef REGFILE_BYPASS_EN
      .we0    (we0),
      .wreg0  (wreg0),
      .wdata0 (wdata0),
      .we1    (we1),
      .wreg1  (wreg1),
      .wdata1 (wdata1),
`endif
      .rdata  (rdata[k*REG_SIZE +: REG_SIZE])
    );
  end

endmodule
